// File: rtl/fetch_ctrl_pkg.sv
// Shared state encoding and instruction decode helpers for the nanoprocessor fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [1:0] OPC_CTRL      = 2'b11;
    localparam int         CTRL_HALT_BIT = 5;

    function automatic logic is_ctrl(input logic [7:0] ir);
        return ir[7:6] == OPC_CTRL;
    endfunction

    function automatic logic is_halt(input logic [7:0] ir);
        return (ir[7:6] == OPC_CTRL) && ir[CTRL_HALT_BIT];
    endfunction

    function automatic logic [3:0] jump_target(input logic [7:0] ir);
        return ir[3:0];
    endfunction

endpackage

// File: rtl/fetch_controller_program_counter.sv
// Program counter register: clear beats load beats increment; wraps modulo 2**ADDR_W.
module program_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr) begin
            pc_d = '0;
        end else if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch/issue sequencer: walks the program ROM, resolves JZR/HALT locally and
// hands datapath ops out over a valid/ready handshake.
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               zero_flag,
    output logic               exec_valid,
    input  logic               exec_ready,
    output logic [INSTR_W-1:0] exec_instr,
    output logic               busy,
    output logic               halted,
    output logic               jump_taken
);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q;
    logic               ir_load;
    logic               stop_pend_q, stop_pend_d;
    logic               stop_now;
    logic               pc_clr, pc_inc, pc_load;
    logic [ADDR_W-1:0]  pc;

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pc_clr),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (ADDR_W'(jump_target(ir_q))),
        .pc       (pc)
    );

    assign stop_now = stop_pend_q | stop;

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        ir_load     = 1'b0;
        pc_clr      = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        exec_valid  = 1'b0;
        jump_taken  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = FETCH;
                    pc_clr  = 1'b1;
                end
            end
            FETCH: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    ir_load = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!is_ctrl(ir_q)) begin
                    // A stop here is only remembered; the pending handshake must finish first.
                    exec_valid = 1'b1;
                    if (stop) begin
                        stop_pend_d = 1'b1;
                    end
                    if (exec_ready) begin
                        pc_inc  = 1'b1;
                        state_d = stop_now ? IDLE : FETCH;
                    end
                end else if (is_halt(ir_q)) begin
                    state_d = stop_now ? IDLE : HALTED;
                end else begin
                    if (zero_flag) begin
                        pc_load    = 1'b1;
                        jump_taken = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                    state_d = stop_now ? IDLE : FETCH;
                end
            end
            HALTED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = FETCH;
                    pc_clr  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            stop_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            if (ir_load) begin
                ir_q <= rom_data;
            end
        end
    end

    assign rom_addr   = pc;
    assign exec_instr = ir_q;
    assign busy       = (state_q == FETCH) || (state_q == ISSUE);
    assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a behavioural ROM and hand-derived expectations.
module tb_fetch_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       zero_flag;
    logic       exec_valid;
    logic       exec_ready;
    logic [7:0] exec_instr;
    logic       busy;
    logic       halted;
    logic       jump_taken;

    logic [7:0] rom [16];
    int         checks   = 0;
    int         failures = 0;
    int         acc_cnt  = 0;
    int         acc_base;
    int         wait_cyc;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    fetch_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .zero_flag  (zero_flag),
        .exec_valid (exec_valid),
        .exec_ready (exec_ready),
        .exec_instr (exec_instr),
        .busy       (busy),
        .halted     (halted),
        .jump_taken (jump_taken)
    );

    always @(posedge clk) begin
        if (exec_valid && exec_ready) begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    task automatic wait_halted(input string tag);
        wait_cyc = 0;
        while (!halted && wait_cyc < 60) begin
            tick();
            wait_cyc++;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        zero_flag  = 1'b0;
        exec_ready = 1'b1;
        fill_rom(8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_addr",   rom_addr,   0);
        check("rst_valid",  exec_valid, 0);
        check("rst_instr",  exec_instr, 0);
        check("rst_busy",   busy,       0);
        check("rst_halted", halted,     0);
        check("rst_jump",   jump_taken, 0);

        // straight-line program ending in HALT
        rom[0] = 8'h1C; rom[1] = 8'h02; rom[2] = 8'h01; rom[3] = 8'hE0;
        pulse_start();
        check("t1_c1_busy",  busy, 1);
        check("t1_c1_addr",  rom_addr, 0);
        check("t1_c1_valid", exec_valid, 0);
        tick(); check("t1_c2_valid", exec_valid, 1); check("t1_c2_instr", exec_instr, 8'h1C);
        tick(); check("t1_c3_valid", exec_valid, 0); check("t1_c3_addr", rom_addr, 1);
        tick(); check("t1_c4_instr", exec_instr, 8'h02);
        tick();
        tick(); check("t1_c6_instr", exec_instr, 8'h01); check("t1_c6_valid", exec_valid, 1);
        tick(); check("t1_c7_addr", rom_addr, 3);
        tick(); check("t1_c8_valid", exec_valid, 0); check("t1_c8_halted", halted, 0);
        tick(); check("t1_c9_halted", halted, 1); check("t1_c9_addr", rom_addr, 3);
        check("t1_c9_busy", busy, 0);

        // JZR taken
        fill_rom(8'h00);
        rom[0] = 8'h1C; rom[1] = 8'hC5; rom[5] = 8'hE0;
        zero_flag = 1'b1;
        pulse_start();
        check("t2_c1_addr", rom_addr, 0);
        tick(); tick(); check("t2_c3_addr", rom_addr, 1);
        tick(); check("t2_c4_jump", jump_taken, 1); check("t2_c4_valid", exec_valid, 0);
        tick(); check("t2_c5_addr", rom_addr, 5); check("t2_c5_jump", jump_taken, 0);
        tick();
        tick(); check("t2_c7_halted", halted, 1); check("t2_c7_addr", rom_addr, 5);

        // JZR not taken: falls through 2,3,4 then HALT at 5
        zero_flag = 1'b0;
        pulse_start();
        tick(); tick(); tick();
        check("t2n_c4_jump", jump_taken, 0);
        tick(); check("t2n_c5_addr", rom_addr, 2);
        wait_halted("t2n_halt");
        check("t2n_addr", rom_addr, 5);

        // stalled handshake
        fill_rom(8'h00);
        rom[0] = 8'h1C; rom[1] = 8'hE0;
        exec_ready = 1'b0;
        pulse_start();
        acc_base = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_stall%0d_valid", i), exec_valid, 1);
            check($sformatf("t3_stall%0d_instr", i), exec_instr, 8'h1C);
            check($sformatf("t3_stall%0d_addr", i),  rom_addr, 0);
        end
        exec_ready = 1'b1;
        tick(); check("t3_after_addr", rom_addr, 1); check("t3_acc", acc_cnt - acc_base, 1);
        wait_halted("t3_halt");

        // PC wrap with no HALT in the ROM
        fill_rom(8'h10);
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            check($sformatf("t4_fetch%0d_addr", i), rom_addr, i % 16);
            tick();
            check($sformatf("t4_issue%0d_valid", i), exec_valid, 1);
            if (i == 16) stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        check("t4_stop_busy", busy, 0);
        check("t4_stop_addr", rom_addr, 1);

        // stop during a stalled ISSUE
        exec_ready = 1'b0;
        pulse_start();
        tick(); check("t5_issue_valid", exec_valid, 1);
        acc_base = acc_cnt;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_pending_valid", exec_valid, 1);
        exec_ready = 1'b1;
        tick();
        check("t5_acc", acc_cnt - acc_base, 1);
        check("t5_busy", busy, 0);
        check("t5_valid", exec_valid, 0);
        check("t5_addr", rom_addr, 1);
        tick(); check("t5_idle_hold", busy, 0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("t5_ss_busy", busy, 0);
        tick(); check("t5_ss_busy2", busy, 0);

        // asynchronous reset mid-ISSUE
        exec_ready = 1'b0;
        pulse_start();
        tick(); check("t6_pre_valid", exec_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", exec_valid, 0);
        check("t6_rst_instr", exec_instr, 0);
        check("t6_rst_busy",  busy, 0);
        check("t6_rst_addr",  rom_addr, 0);
        tick();
        rst_n = 1'b1;
        exec_ready = 1'b1;
        pulse_start();
        check("t6_resume_addr", rom_addr, 0);
        tick(); check("t6_resume_instr", exec_instr, 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
